// File: rtl/lcd_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the PCF8574/HD44780 LCD path: backpack pin map,
// default target address and the I2C target FSM encoding.
package lcd_pkg;

  localparam int unsigned PCF_RS    = 0;
  localparam int unsigned PCF_RW    = 1;
  localparam int unsigned PCF_EN    = 2;
  localparam int unsigned PCF_BL    = 3;
  localparam int unsigned PCF_D_LSB = 4;

  localparam logic [6:0] LCD_I2C_ADDR = 7'h27;

  typedef enum logic [2:0] {
    TGT_IDLE,
    TGT_ADDR,
    TGT_ADDR_ACK,
    TGT_DATA,
    TGT_DATA_ACK,
    TGT_WAIT_STOP
  } tgt_state_t;

endpackage

// File: rtl/i2c_target_phy.sv
`timescale 1ns/1ps
// Write-only I2C target: synchronises SCL/SDA, detects START/STOP, shifts bytes, drives ACK.
// Byte strobe one clk after the synced 8th SCL fall; no clock stretching, master is never held off.
module i2c_target_phy
  import lcd_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR    = LCD_I2C_ADDR,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk_1MHz,
  input  logic       rst_n,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_sda_oe,
  output logic [7:0] o_byte,
  output logic       o_byte_vld,
  output logic       o_busy
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_d;
  logic                   r_sda_d;
  logic                   w_scl;
  logic                   w_sda;
  logic                   w_start;
  logic                   w_stop;
  logic                   w_scl_rise;
  logic                   w_scl_fall;
  logic                   w_byte_done;
  tgt_state_t             r_state;
  tgt_state_t             w_state_nxt;
  logic [7:0]             r_shift;
  logic [3:0]             r_bit_cnt;
  logic [7:0]             r_byte;
  logic                   r_byte_vld;

  // Preset to 1 so the bus reads as idle-high coming out of reset.
  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
    end
  end

  assign w_scl       = r_scl_sync[SYNC_STAGES-1];
  assign w_sda       = r_sda_sync[SYNC_STAGES-1];
  assign w_start     = w_scl && r_scl_d && r_sda_d && !w_sda;
  assign w_stop      = w_scl && r_scl_d && !r_sda_d && w_sda;
  assign w_scl_rise  = w_scl && !r_scl_d;
  assign w_scl_fall  = !w_scl && r_scl_d;
  assign w_byte_done = w_scl_fall && (r_bit_cnt == 4'd8);

  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) r_state <= TGT_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_start) begin
      w_state_nxt = TGT_ADDR;
    end else if (w_stop) begin
      w_state_nxt = TGT_IDLE;
    end else begin
      case (r_state)
        TGT_ADDR: begin
          if (w_byte_done) begin
            if (r_shift[7:1] == I2C_ADDR && !r_shift[0]) w_state_nxt = TGT_ADDR_ACK;
            else                                         w_state_nxt = TGT_WAIT_STOP;
          end
        end
        TGT_ADDR_ACK: if (w_scl_fall)  w_state_nxt = TGT_DATA;
        TGT_DATA:     if (w_byte_done) w_state_nxt = TGT_DATA_ACK;
        TGT_DATA_ACK: if (w_scl_fall)  w_state_nxt = TGT_DATA;
        default:      w_state_nxt = r_state;
      endcase
    end
  end

  // ACK drive follows the state register, so async reset releases SDA at once.
  always_comb begin
    o_sda_oe = (r_state == TGT_ADDR_ACK) || (r_state == TGT_DATA_ACK);
    o_busy   = (r_state != TGT_IDLE);
  end

  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_byte     <= '0;
      r_byte_vld <= 1'b0;
    end else begin
      r_byte_vld <= 1'b0;
      if (w_start) begin
        r_bit_cnt <= '0;
      end else if ((r_state == TGT_ADDR || r_state == TGT_DATA) && w_scl_rise &&
                   (r_bit_cnt < 4'd8)) begin
        r_shift   <= {r_shift[6:0], w_sda};
        r_bit_cnt <= r_bit_cnt + 4'd1;
      end else if ((r_state == TGT_ADDR_ACK || r_state == TGT_DATA_ACK) && w_scl_fall) begin
        r_bit_cnt <= '0;
      end
      if (r_state == TGT_DATA && w_byte_done) begin
        r_byte     <= r_shift;
        r_byte_vld <= 1'b1;
      end
    end
  end

  assign o_byte     = r_byte;
  assign o_byte_vld = r_byte_vld;

endmodule

// File: rtl/i2c_lcd_backpack_rx.sv
`timescale 1ns/1ps
// PCF8574 LCD backpack mirror: I2C target plus HD44780 nibble reassembly on EN falling edges.
// Port/LCD pulses one clk after the byte strobe; no backpressure, pulses are never held.
module i2c_lcd_backpack_rx
  import lcd_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR    = LCD_I2C_ADDR,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk_1MHz,
  input  logic       rst_n,
  input  logic       i_scl,
  inout  wire        io_sda,
  output logic [7:0] o_port_byte,
  output logic       o_port_valid,
  output logic [7:0] o_lcd_byte,
  output logic       o_lcd_rs,
  output logic       o_lcd_valid,
  output logic       o_backlight,
  output logic       o_four_bit,
  output logic       o_busy
);

  logic       w_sda_oe;
  logic [7:0] w_byte;
  logic       w_byte_vld;
  logic [3:0] w_nib;
  logic       w_en_fall;
  logic       r_prev_en;
  logic       r_phase_low;
  logic [3:0] r_hi;
  logic       r_rs_hi;

  assign io_sda = w_sda_oe ? 1'b0 : 1'bz;

  i2c_target_phy #(
    .I2C_ADDR    (I2C_ADDR),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_phy (
    .clk_1MHz   (clk_1MHz),
    .rst_n      (rst_n),
    .i_scl      (i_scl),
    .i_sda      (io_sda),
    .o_sda_oe   (w_sda_oe),
    .o_byte     (w_byte),
    .o_byte_vld (w_byte_vld),
    .o_busy     (o_busy)
  );

  assign w_nib     = w_byte[PCF_D_LSB +: 4];
  assign w_en_fall = r_prev_en && !w_byte[PCF_EN];

  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      o_port_byte  <= '0;
      o_port_valid <= 1'b0;
      o_lcd_byte   <= '0;
      o_lcd_rs     <= 1'b0;
      o_lcd_valid  <= 1'b0;
      o_backlight  <= 1'b0;
      o_four_bit   <= 1'b0;
      r_prev_en    <= 1'b0;
      r_phase_low  <= 1'b0;
      r_hi         <= '0;
      r_rs_hi      <= 1'b0;
    end else begin
      o_port_valid <= 1'b0;
      o_lcd_valid  <= 1'b0;
      if (w_byte_vld) begin
        o_port_byte  <= w_byte;
        o_port_valid <= 1'b1;
        r_prev_en    <= w_byte[PCF_EN];
        o_backlight  <= w_byte[PCF_BL];
        if (w_en_fall && !w_byte[PCF_RW]) begin
          if (!o_four_bit) begin
            o_lcd_byte  <= {w_nib, 4'h0};
            o_lcd_rs    <= w_byte[PCF_RS];
            o_lcd_valid <= 1'b1;
            // Function-set with DL=0 while in 8-bit mode switches the interface.
            if (!w_byte[PCF_RS] && w_nib == 4'h2) begin
              o_four_bit  <= 1'b1;
              r_phase_low <= 1'b0;
            end
          end else if (!r_phase_low) begin
            r_hi        <= w_nib;
            r_rs_hi     <= w_byte[PCF_RS];
            r_phase_low <= 1'b1;
          end else begin
            o_lcd_byte  <= {r_hi, w_nib};
            o_lcd_rs    <= r_rs_hi;
            o_lcd_valid <= 1'b1;
            r_phase_low <= 1'b0;
            if (!r_rs_hi && r_hi == 4'h3) o_four_bit <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_lcd_backpack_rx.sv
`timescale 1ns/1ps
// Directed I2C master stimulus with queued expectations checked by a free-running monitor.
module tb_i2c_lcd_backpack_rx;

  localparam int Q = 3000;

  typedef struct {
    logic [7:0] b;
    logic       rs;
  } lcd_exp_t;

  logic       clk_1MHz = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       tb_sda_low = 1'b0;
  wire        sda;
  logic [7:0] o_port_byte;
  logic       o_port_valid;
  logic [7:0] o_lcd_byte;
  logic       o_lcd_rs;
  logic       o_lcd_valid;
  logic       o_backlight;
  logic       o_four_bit;
  logic       o_busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_port[$];
  lcd_exp_t   exp_lcd[$];

  assign sda = tb_sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  always #500 clk_1MHz = ~clk_1MHz;

  i2c_lcd_backpack_rx #(
    .I2C_ADDR    (7'h27),
    .SYNC_STAGES (2)
  ) dut (
    .clk_1MHz     (clk_1MHz),
    .rst_n        (rst_n),
    .i_scl        (scl),
    .io_sda       (sda),
    .o_port_byte  (o_port_byte),
    .o_port_valid (o_port_valid),
    .o_lcd_byte   (o_lcd_byte),
    .o_lcd_rs     (o_lcd_rs),
    .o_lcd_valid  (o_lcd_valid),
    .o_backlight  (o_backlight),
    .o_four_bit   (o_four_bit),
    .o_busy       (o_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic i2c_start();
    tb_sda_low = 1'b0; #Q;
    scl = 1'b1;        #Q;
    tb_sda_low = 1'b1; #Q;
    scl = 1'b0;        #Q;
  endtask

  task automatic i2c_stop();
    tb_sda_low = 1'b1; #Q;
    scl = 1'b1;        #Q;
    tb_sda_low = 1'b0; #Q;
  endtask

  task automatic send_bit(input logic b);
    tb_sda_low = !b; #Q;
    scl = 1'b1;      #(2*Q);
    scl = 1'b0;      #Q;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    tb_sda_low = 1'b0; #Q;
    scl = 1'b1;        #Q;
    ack = (sda === 1'b0);
    #Q;
    scl = 1'b0;        #Q;
  endtask

  task automatic start_addr(input logic [7:0] a, input logic exp_ack);
    logic ack;
    i2c_start();
    chk("busy_after_start", o_busy, 1);
    send_byte(a, ack);
    chk("addr_ack", ack, exp_ack);
  endtask

  task automatic wr(input logic [7:0] b);
    logic ack;
    exp_port.push_back(b);
    send_byte(b, ack);
    chk("data_ack", ack, 1);
  endtask

  task automatic push_lcd(input logic [7:0] b, input logic rs);
    lcd_exp_t e;
    e.b  = b;
    e.rs = rs;
    exp_lcd.push_back(e);
  endtask

  // Monitor: every output pulse consumes the oldest expectation.
  initial begin
    forever begin
      @(negedge clk_1MHz);
      if (o_port_valid) begin
        if (exp_port.size() == 0) chk("unexpected_port_valid", {24'h0, o_port_byte}, 32'hFFFF_FFFF);
        else                      chk("port_byte", o_port_byte, exp_port.pop_front());
      end
      if (o_lcd_valid) begin
        if (exp_lcd.size() == 0) begin
          chk("unexpected_lcd_valid", {24'h0, o_lcd_byte}, 32'hFFFF_FFFF);
        end else begin
          lcd_exp_t e;
          e = exp_lcd.pop_front();
          chk("lcd_byte", o_lcd_byte, e.b);
          chk("lcd_rs", o_lcd_rs, e.rs);
        end
      end
    end
  end

  initial begin
    logic ack;
    #2700;
    chk("reset_outputs_in_reset",
        {o_port_byte, o_port_valid, o_lcd_byte, o_lcd_rs, o_lcd_valid, o_backlight, o_four_bit, o_busy}, 0);
    chk("reset_sda_released", sda, 1);
    rst_n = 1'b1;
    #Q;
    chk("idle_busy", o_busy, 0);
    chk("idle_four_bit", o_four_bit, 0);

    // 8-bit mode: one EN pulse yields the high nibble as a full byte.
    start_addr(8'h4E, 1'b1);
    wr(8'h3C);
    push_lcd(8'h30, 1'b0);
    wr(8'h38);
    i2c_stop();
    chk("busy_after_stop", o_busy, 0);
    chk("backlight_on", o_backlight, 1);
    chk("port_byte_last", o_port_byte, 8'h38);
    chk("four_bit_still_0", o_four_bit, 0);

    // Init sequence, ending with the 4-bit function set.
    start_addr(8'h4E, 1'b1);
    for (int i = 0; i < 3; i++) begin
      wr(8'h3C);
      push_lcd(8'h30, 1'b0);
      wr(8'h38);
    end
    wr(8'h2C);
    push_lcd(8'h20, 1'b0);
    wr(8'h28);
    i2c_stop();
    chk("four_bit_entered", o_four_bit, 1);

    // 4-bit data 'A', an RW=1 strobe that must not latch, then back to 8-bit mode.
    start_addr(8'h4E, 1'b1);
    wr(8'h4D);
    wr(8'h49);
    wr(8'h1D);
    push_lcd(8'h41, 1'b1);
    wr(8'h19);
    wr(8'h3E);
    wr(8'h3A);
    wr(8'h3C);
    wr(8'h38);
    wr(8'h0C);
    push_lcd(8'h30, 1'b0);
    wr(8'h08);
    i2c_stop();
    chk("four_bit_exit", o_four_bit, 0);
    chk("lcd_rs_held", o_lcd_rs, 0);

    start_addr(8'h4E, 1'b1);
    wr(8'h2C);
    push_lcd(8'h20, 1'b0);
    wr(8'h28);
    wr(8'h00);
    i2c_stop();
    chk("four_bit_reentered", o_four_bit, 1);
    chk("backlight_off", o_backlight, 0);

    // Wrong address and read requests are NACKed and produce no port bytes.
    start_addr(8'h4C, 1'b0);
    send_byte(8'h55, ack);
    chk("nack_data_wrong_addr", ack, 0);
    chk("busy_in_wait_stop", o_busy, 1);
    i2c_stop();
    chk("busy_after_nack_stop", o_busy, 0);
    start_addr(8'h4F, 1'b0);
    i2c_stop();
    chk("busy_after_read_stop", o_busy, 0);

    // Repeated START part-way through a data byte discards the partial bits.
    start_addr(8'h4E, 1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    start_addr(8'h4E, 1'b1);
    wr(8'h08);
    i2c_stop();
    chk("port_byte_after_rstart", o_port_byte, 8'h08);
    chk("backlight_after_rstart", o_backlight, 1);

    // Reset while the target holds SDA low for the address ACK.
    i2c_start();
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] a;
      a = 8'h4E;
      send_bit(a[i]);
    end
    tb_sda_low = 1'b0; #Q;
    scl = 1'b1;        #Q;
    chk("sda_ack_before_reset", sda, 0);
    chk("busy_before_reset", o_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("sda_released_by_reset", sda, 1);
    chk("outputs_after_reset",
        {o_port_byte, o_port_valid, o_lcd_byte, o_lcd_rs, o_lcd_valid, o_backlight, o_four_bit, o_busy}, 0);
    #Q;
    scl = 1'b0; #Q;
    scl = 1'b1; #Q;
    rst_n = 1'b1;
    #(2*Q);
    chk("busy_after_reset_release", o_busy, 0);
    chk("four_bit_after_reset", o_four_bit, 0);

    chk("port_queue_drained", exp_port.size(), 0);
    chk("lcd_queue_drained", exp_lcd.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_lcd_backpack_rx.md
Name: i2c_lcd_backpack_rx

Overview:
- I2C target (responder) modelling the PCF8574 LCD backpack at the far end of our LCD write path.
- Oversamples SCL/SDA on clk_1MHz, ACKs writes to its address and decodes each received port byte into HD44780 pin activity.
- Reassembles nibble pairs into LCD command/data bytes on EN falling edges.
- Used as an on-chip mirror and loopback checker for the LCD writer, and as the DUT-side model in system benches.

Parameters:
- I2C_ADDR, 7'h27, 7-bit target address answered.
- SYNC_STAGES, 2, synchronizer depth on SCL/SDA (min 2).

Ports:
- clk_1MHz  in  1  sampling clock; SCL must be ≤100 kHz (≥10 samples per bit).
- rst_n  in  1  asynchronous, active-low reset.
- scl  in  1  I2C clock, input only (no clock stretching).
- sda  inout  1  I2C data, open-drain: driven 0 or released to Z.
- port_byte  out  8  last received PCF8574 port byte. P0=RS, P1=RW, P2=EN, P3=BL, P7..P4=D7..D4.
- port_valid  out  1  1-cycle pulse when port_byte updates.
- lcd_byte  out  8  reassembled LCD byte.
- lcd_rs  out  1  RS accompanying lcd_byte (0=command, 1=data).
- lcd_valid  out  1  1-cycle pulse when lcd_byte/lcd_rs update.
- backlight  out  1  P3 of last port byte.
- four_bit  out  1  current HD44780 interface mode.
- busy  out  1  high from START until STOP.

Behaviour:
- Reset (async): all outputs 0, sda released (Z), FSM IDLE, four_bit=0, nibble phase=HIGH, prev_en=0, synchronizers preset to 1.
- SCL/SDA pass SYNC_STAGES flops, plus one extra flop for edge detection. Events are computed on synced signals:
  - START: SDA falls while SCL high.
  - STOP: SDA rises while SCL high.
  - SCL rise / SCL fall.
- START or repeated START in any state: clear bit counter, go to ADDR, busy=1.
- STOP in any state: go to IDLE, release sda, busy=0. Nibble phase and mode are kept.
- FSM states:
  - IDLE → ADDR on START.
  - ADDR: shift SDA MSB-first on each SCL rise; 8 bits.
    - On the SCL fall after bit 8: if addr==I2C_ADDR and R/W=0, go to ADDR_ACK and drive sda=0.
    - Otherwise go to WAIT_STOP with sda released. Reads are NACKed.
  - ADDR_ACK: hold sda=0 through the 9th SCL pulse; release on the next SCL fall, then go to DATA.
  - DATA: shift 8 bits the same way. On the SCL fall after bit 8:
    - drive sda=0, go to DATA_ACK;
    - load port_byte, pulse port_valid, run the decode step.
  - DATA_ACK: release on the next SCL fall, then go to DATA. Unbounded bytes per transaction.
  - WAIT_STOP: sda released; ignore everything until STOP or START.
- ACK timing: sda is driven within SYNC_STAGES+2 clk cycles of the SCL fall. This is well inside the SCL-low half at ≤100 kHz.
- Decode step, per port byte b:
  - EN fall = prev_en=1 and b[2]=0. Then prev_en←b[2] and backlight←b[3].
  - On EN fall with RW=1: no latch.
  - On EN fall with RW=0:
    - four_bit=0: lcd_byte={b[7:4],4'h0}, lcd_rs=b[0], pulse lcd_valid. If RS=0 and b[7:4]==4'h2, set four_bit=1 and phase=HIGH.
    - four_bit=1, phase HIGH: store hi=b[7:4], rs_hi=b[0], phase=LOW. No output.
    - four_bit=1, phase LOW: lcd_byte={hi,b[7:4]}, lcd_rs=rs_hi, pulse lcd_valid, phase=HIGH. If rs_hi=0 and hi==4'h3, set four_bit=0.
  - A LOW nibble whose RS differs from rs_hi still completes the byte using rs_hi.
- port_valid and lcd_valid may pulse in the same cycle. lcd_valid's outputs are stable until the next pulse.
- Reset mid-transaction: sda released immediately (async), FSM to IDLE. A partial byte is discarded.
- Glitch filtering: none beyond synchronizers. Bits are sampled only on synced SCL rise.

Decomposition:
- Shared package lcd_pkg:
  - PCF8574 bit-index constants (RS=0, RW=1, EN=2, BL=3, D_LSB=4);
  - default LCD I2C address 7'h27;
  - target FSM state enum.
- Sub-module i2c_target_phy: synchronizers, START/STOP/edge detection, address/data shifting, ACK drive. Outputs byte + strobe.
- HD44780 nibble decode lives in the top of this block.

Test Plan:
- Write addr 0x27 and byte 0x3C, then 0x38 → ACK on both the address and data 9th clocks. port_byte=0x38, backlight=1. In 8-bit mode: lcd_valid once with lcd_byte=0x30, lcd_rs=0.
- Init sequence 0x3C/0x38 ×3, then 0x2C/0x28 → four lcd_valid pulses (0x30,0x30,0x30,0x20); four_bit=1 after the last.
- In 4-bit mode, send 'A' as 0x4D,0x49,0x1D,0x19 → one lcd_valid, lcd_byte=0x41, lcd_rs=1. No pulse after the first nibble.
- Address 0x26, or 0x27 with R/W=1 → sda never driven low (NACK), no port_valid. busy falls on STOP.
- Repeated START mid-data byte, then new address 0x27 + byte 0x08 → ACK. The partial byte is dropped; port_byte=0x08.
- Assert rst_n low while sda is driven for ACK → sda Z in the same cycle; all outputs 0, four_bit=0.
